// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the video test-pattern / compositor slice.
//   rgb565_t   : 16-bit RGB565 pixel {R[4:0], G[5:0], B[4:0]}
//   pattern_e  : test-pattern selector
//   split_e    : camera/pattern split mode
//   pos_state_e: frame-tracking FSM state (exported for debug/checkers)
//   WHITE/BLACK/RED colour constants, rgb565_pack() helper
// -----------------------------------------------------------------------------
package video_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    SPL_TPG = 2'd0,  // pattern only
    SPL_CAM = 2'd1,  // camera only
    SPL_Y   = 2'd2,  // camera when y >= pos
    SPL_X   = 2'd3   // camera when x >= pos
  } split_e;

  typedef enum logic {
    ST_WAIT_VS = 1'b0,
    ST_RUN     = 1'b1
  } pos_state_e;

  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t RED   = 16'hF800;

  function automatic rgb565_t rgb565_pack(input logic [4:0] r,
                                          input logic [5:0] g,
                                          input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/video_pos_counter.sv
// -----------------------------------------------------------------------------
// video_pos_counter
// Tracks the active-pixel position from the incoming sync/de stream, detects
// the frame-start edge of vs, latches the shadow configuration on that edge
// and runs the WAIT_VS/RUN frame-tracking FSM.
//
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   in_vs, in_de        incoming vertical sync / active video
//   cfg_pattern/split/pos  live configuration (sampled only at frame start)
//   x, y                current pixel / line index (valid for the pixel on in_de)
//   bar_idx             colour-bar index of the current pixel
//   frame_start         one-cycle pulse, combinational on the active vs edge
//   sh_pattern/sh_split/sh_pos  shadow configuration
//   state               FSM state, exported for debug
// -----------------------------------------------------------------------------
module video_pos_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int NUM_BARS = 16,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vs,
  input  logic          in_de,
  input  logic [1:0]    cfg_pattern,
  input  logic [1:0]    cfg_split,
  input  logic [CW-1:0] cfg_pos,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [3:0]    bar_idx,
  output logic          frame_start,
  output pattern_e      sh_pattern,
  output split_e        sh_split,
  output logic [CW-1:0] sh_pos,
  output pos_state_e    state
);

  localparam int            BW      = H_ACTIVE / NUM_BARS;
  localparam logic [CW-1:0] X_MAX   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] BW_MAX  = CW'(BW - 1);
  localparam logic [3:0]    IDX_MAX = 4'(NUM_BARS - 1);

  pos_state_e    state_nxt;
  logic          vs_act, vs_act_q, vs_edge;
  logic          de_q, de_fall;
  logic [CW-1:0] bar_cnt;

  // vs_act_q resets to "active" so a vs pulse already in progress at reset
  // release is not mistaken for a fresh frame start.
  assign vs_act      = (in_vs == VS_POL);
  assign vs_edge     = vs_act & ~vs_act_q;
  assign de_fall     = de_q & ~in_de;
  assign frame_start = vs_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q <= 1'b1;
      de_q     <= 1'b0;
    end else begin
      vs_act_q <= vs_act;
      de_q     <= in_de;
    end
  end

  // Frame-tracking FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_VS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_VS: if (vs_edge) state_nxt = ST_RUN;
      ST_RUN:     state_nxt = ST_RUN;
      default:    state_nxt = ST_WAIT_VS;
    endcase
  end

  // Position and bar counters. x is the index of the pixel currently on
  // in_de, so it is 0 on the first de cycle of every line. The vs edge has
  // priority over a coincident de falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (vs_edge) begin
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (!in_de)          x <= '0;
      else if (x != X_MAX) x <= x + CW'(1);

      if (de_fall && (y != Y_MAX)) y <= y + CW'(1);

      // Bar index advances every BW pixels without a divider.
      if (!in_de) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BW_MAX) begin
        bar_cnt <= '0;
        if (bar_idx != IDX_MAX) bar_idx <= bar_idx + 4'd1;
      end else begin
        bar_cnt <= bar_cnt + CW'(1);
      end
    end
  end

  // Shadow configuration, only updated at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pattern <= PAT_BARS;
      sh_split   <= SPL_TPG;
      sh_pos     <= '0;
    end else if (vs_edge) begin
      sh_pattern <= pattern_e'(cfg_pattern);
      sh_split   <= split_e'(cfg_split);
      sh_pos     <= cfg_pos;
    end
  end

endmodule

// File: rtl/video_mux_tpg.sv
// -----------------------------------------------------------------------------
// video_mux_tpg
// Test-pattern generator and camera compositor placed between the display
// timing generator and the DVI transmitter. Generates one of four RGB565
// patterns (bars, gradient, checker, solid white), merges it with the camera
// stream according to the split mode, and delays sync/de by the same two
// cycles as the pixel pipeline.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   cfg_pattern[1:0]      0 bars, 1 gradient, 2 checker, 3 solid white
//   cfg_split[1:0]        0 pattern, 1 camera, 2 camera when y>=pos,
//                         3 camera when x>=pos
//   cfg_pos[CW-1:0]       split position (line or pixel)
//   in_vs, in_hs, in_de   incoming timing
//   cam_rgb[15:0]         camera pixel aligned with in_de
//   out_vs/out_hs/out_de  timing delayed by 2 cycles
//   out_rgb[15:0]         composed pixel (0 outside active video)
//   frame_start           one-cycle pulse on the active vs edge
//
// Build option: define VIDEO_MUX_TPG_BORDER_EN to draw a red boundary line at
// the split position in modes 2/3.
//
// x[9:5] and y[9:4] feed the gradient, so CW must be at least 10, and
// CHECK_LOG2 must be below CW.
// -----------------------------------------------------------------------------
module video_mux_tpg
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int NUM_BARS   = 16,
  parameter int CHECK_LOG2 = 5,
  parameter bit VS_POL     = 1'b1,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cfg_pattern,
  input  logic [1:0]    cfg_split,
  input  logic [CW-1:0] cfg_pos,
  input  logic          in_vs,
  input  logic          in_hs,
  input  logic          in_de,
  input  logic [15:0]   cam_rgb,
  output logic          out_vs,
  output logic          out_hs,
  output logic          out_de,
  output logic [15:0]   out_rgb,
  output logic          frame_start
);

  localparam logic [3:0] BAR_STEP = 4'(16 / NUM_BARS);

  logic [CW-1:0] x, y, sh_pos;
  logic [3:0]    bar_idx, bar_shift;
  pattern_e      sh_pattern;
  split_e        sh_split, eff_split;
  pos_state_e    state;

  rgb565_t pat_pix, s1_src;
  logic    sel_cam, s1_sel_src;

  rgb565_t s1_pix, s1_cam;
  logic    s1_sel, s1_vs, s1_hs, s1_de;

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .NUM_BARS (NUM_BARS),
    .VS_POL   (VS_POL),
    .CW       (CW)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vs       (in_vs),
    .in_de       (in_de),
    .cfg_pattern (cfg_pattern),
    .cfg_split   (cfg_split),
    .cfg_pos     (cfg_pos),
    .x           (x),
    .y           (y),
    .bar_idx     (bar_idx),
    .frame_start (frame_start),
    .sh_pattern  (sh_pattern),
    .sh_split    (sh_split),
    .sh_pos      (sh_pos),
    .state       (state)
  );

  // Until the first frame start y is meaningless, so only the pattern is shown.
  assign eff_split = (state == ST_RUN) ? sh_split : SPL_TPG;

  // One-hot bar colour: bit (15 - idx*16/NUM_BARS). idx*step stays below 16.
  assign bar_shift = bar_idx * BAR_STEP;

  always_comb begin
    pat_pix = BLACK;
    case (sh_pattern)
      PAT_BARS:  pat_pix = rgb565_t'(16'h8000 >> bar_shift);
      PAT_GRAD:  pat_pix = rgb565_pack(x[9:5], y[9:4], ~x[9:5]);
      PAT_CHECK: pat_pix = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? WHITE : BLACK;
      PAT_SOLID: pat_pix = WHITE;
      default:   pat_pix = BLACK;
    endcase
  end

  always_comb begin
    sel_cam = 1'b0;
    case (eff_split)
      SPL_TPG: sel_cam = 1'b0;
      SPL_CAM: sel_cam = 1'b1;
      SPL_Y:   sel_cam = (y >= sh_pos);
      SPL_X:   sel_cam = (x >= sh_pos);
      default: sel_cam = 1'b0;
    endcase
  end

`ifdef VIDEO_MUX_TPG_BORDER_EN
  // The boundary pixel is replaced by red and routed through the pattern
  // leg of the mux, so the pipeline depth is unchanged.
  logic on_border;

  always_comb begin
    on_border = 1'b0;
    case (eff_split)
      SPL_Y:   on_border = (y == sh_pos);
      SPL_X:   on_border = (x == sh_pos);
      default: on_border = 1'b0;
    endcase
  end

  assign s1_src     = on_border ? RED : pat_pix;
  assign s1_sel_src = sel_cam & ~on_border;
`else
  assign s1_src     = pat_pix;
  assign s1_sel_src = sel_cam;
`endif

  // Stage 1: pattern pixel, camera pixel, select and timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pix <= BLACK;
      s1_cam <= BLACK;
      s1_sel <= 1'b0;
      s1_vs  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_de  <= 1'b0;
    end else begin
      s1_pix <= s1_src;
      s1_cam <= cam_rgb;
      s1_sel <= s1_sel_src;
      s1_vs  <= in_vs;
      s1_hs  <= in_hs;
      s1_de  <= in_de;
    end
  end

  // Stage 2: mux result, blanked outside active video.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rgb <= BLACK;
      out_vs  <= 1'b0;
      out_hs  <= 1'b0;
      out_de  <= 1'b0;
    end else begin
      out_rgb <= s1_de ? (s1_sel ? s1_cam : s1_pix) : BLACK;
      out_vs  <= s1_vs;
      out_hs  <= s1_hs;
      out_de  <= s1_de;
    end
  end

endmodule

// File: tb/tb_video_mux_tpg.sv
// -----------------------------------------------------------------------------
// tb_video_mux_tpg
// Directed bench for video_mux_tpg at its default 1280x720 parameters.
// Lines are driven with arbitrary de lengths (short lines are enough to move
// y), outputs are captured two cycles later and compared against hand values
// and a small reference model of the patterns and split rules.
// -----------------------------------------------------------------------------
module tb_video_mux_tpg;

`ifdef VIDEO_MUX_TPG_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam int H = 1280;
  localparam int V = 720;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic [1:0]  cfg_pattern, cfg_split;
  logic [10:0] cfg_pos;
  logic        in_vs, in_hs, in_de;
  logic [15:0] cam_rgb;
  logic        out_vs, out_hs, out_de, frame_start;
  logic [15:0] out_rgb;

  video_mux_tpg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_split   (cfg_split),
    .cfg_pos     (cfg_pos),
    .in_vs       (in_vs),
    .in_hs       (in_hs),
    .in_de       (in_de),
    .cam_rgb     (cam_rgb),
    .out_vs      (out_vs),
    .out_hs      (out_hs),
    .out_de      (out_de),
    .out_rgb     (out_rgb),
    .frame_start (frame_start)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Captured output of the last line: index p+1 holds pixel p, index 0 the
  // blank cycle before the line, index len+1 the blank cycle after it.
  logic [15:0] got_rgb [0:1401];
  logic        got_de  [0:1401];

  // Reference state: shadow config, FSM running flag and current line.
  int sh_pat   = 0;
  int sh_split = 0;
  int sh_pos   = 0;
  bit running  = 1'b0;
  int y_line   = 0;

  function automatic logic [15:0] model_pix(input int x);
    int          xs, sp;
    logic [10:0] xv, yv;
    logic [15:0] pat;
    bit          cam_sel, brd;
    xs = (x > H - 1) ? H - 1 : x;
    xv = 11'(xs);
    yv = 11'(y_line);
    case (sh_pat)
      0:       pat = 16'h8000 >> (xs / 80);
      1:       pat = {xv[9:5], yv[9:4], ~xv[9:5]};
      2:       pat = (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
      default: pat = 16'hFFFF;
    endcase
    sp      = running ? sh_split : 0;
    cam_sel = (sp == 1) || (sp == 2 && y_line >= sh_pos) || (sp == 3 && xs >= sh_pos);
    brd     = (sp == 2 && y_line == sh_pos) || (sp == 3 && xs == sh_pos);
    if (BORDER && brd) return 16'hF800;
    return cam_sel ? cam_rgb : pat;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one line of len de cycles plus two blank cycles, capture the output
  // stream, then check latency, blanking and every pixel against the model.
  task automatic line(input int len, input string tag);
    for (int i = 0; i < len + 2; i++) begin
      in_de = (i < len);
      tick();
      got_de[i]  = out_de;
      got_rgb[i] = out_rgb;
    end
    in_de = 1'b0;
    check({tag, "_de_pre"},    16'(got_de[0]), 16'd0);
    check({tag, "_de_first"},  16'(got_de[1]), 16'd1);
    check({tag, "_de_last"},   16'(got_de[len]), 16'd1);
    check({tag, "_de_post"},   16'(got_de[len + 1]), 16'd0);
    check({tag, "_rgb_blank"}, got_rgb[len + 1], 16'h0000);
    for (int p = 0; p < len; p++)
      check($sformatf("%s_x%0d", tag, p), got_rgb[p + 1], model_pix(p));
    if (y_line < V - 1) y_line++;
  endtask

  task automatic lines(input int n, input int len, input string tag);
    for (int k = 0; k < n; k++) line(len, tag);
  endtask

  // Active vs pulse (with hs) in blanking; checks frame_start and the
  // two-cycle sync delay, then latches the reference shadow config.
  task automatic vs_pulse();
    in_vs = 1'b1;
    in_hs = 1'b1;
    #1;
    check("frame_start_hi", 16'(frame_start), 16'd1);
    tick();
    check("frame_start_lo", 16'(frame_start), 16'd0);
    check("out_vs_d1", 16'(out_vs), 16'd0);
    tick();
    check("out_vs_d2", 16'(out_vs), 16'd1);
    check("out_hs_d2", 16'(out_hs), 16'd1);
    in_vs = 1'b0;
    in_hs = 1'b0;
    tick();
    tick();
    check("out_vs_clr", 16'(out_vs), 16'd0);
    running  = 1'b1;
    sh_pat   = int'(cfg_pattern);
    sh_split = int'(cfg_split);
    sh_pos   = int'(cfg_pos);
    y_line   = 0;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n       = 1'b0;
    cfg_pattern = 2'd0;
    cfg_split   = 2'd1;
    cfg_pos     = 11'd0;
    in_vs       = 1'b0;
    in_hs       = 1'b0;
    in_de       = 1'b0;
    cam_rgb     = 16'h1234;

    repeat (3) @(posedge clk);
    #2;
    check("rst_out_rgb",     out_rgb, 16'h0000);
    check("rst_out_de",      16'(out_de), 16'd0);
    check("rst_out_vs",      16'(out_vs), 16'd0);
    check("rst_out_hs",      16'(out_hs), 16'd0);
    check("rst_frame_start", 16'(frame_start), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Released mid-frame with camera requested: bars until the first vs.
    line(H, "pre_vs");
    check("bar_x0",    got_rgb[1],    16'h8000);
    check("bar_x79",   got_rgb[80],   16'h8000);
    check("bar_x80",   got_rgb[81],   16'h4000);
    check("bar_x1279", got_rgb[1280], 16'h0001);
    vs_pulse();
    line(64, "cam_only");
    check("cam_only_x0", got_rgb[1], 16'h1234);

    // Horizontal split at line 360; pos change mid-frame is deferred.
    cfg_split = 2'd2;
    cfg_pos   = 11'd360;
    cam_rgb   = 16'h07E0;
    vs_pulse();
    cfg_pos = 11'd100;
    line(H, "ysplit_l0");
    lines(358, 4, "ysplit_top");
    line(100, "ysplit_l359");
    check("ysplit_l359_x80", got_rgb[81], 16'h4000);
    line(H, "ysplit_l360");
    check("ysplit_l360_x0", got_rgb[1], BORDER ? 16'hF800 : 16'h07E0);
    line(H, "ysplit_l361");
    check("ysplit_l361_x0", got_rgb[1], 16'h07E0);
    lines(400, 4, "ysplit_sat");
    check("ysplit_sat_x0", got_rgb[1], 16'h07E0);
    vs_pulse();
    lines(100, 4, "ysplit100_top");
    line(16, "ysplit100_l100");
    check("ysplit100_l100_x0", got_rgb[1], BORDER ? 16'hF800 : 16'h07E0);

    // Vertical split at pixel 640 over a 32-pixel checkerboard.
    cfg_pattern = 2'd2;
    cfg_split   = 2'd3;
    cfg_pos     = 11'd640;
    cam_rgb     = 16'h5A5A;
    vs_pulse();
    line(H, "xsplit_l0");
    check("xsplit_l0_x0",   got_rgb[1],   16'h0000);
    check("xsplit_l0_x32",  got_rgb[33],  16'hFFFF);
    check("xsplit_l0_x639", got_rgb[640], 16'hFFFF);
    check("xsplit_l0_x640", got_rgb[641], BORDER ? 16'hF800 : 16'h5A5A);
    check("xsplit_l0_x641", got_rgb[642], 16'h5A5A);
    lines(31, 4, "xsplit_mid");
    line(H, "xsplit_l32");
    check("xsplit_l32_x0",  got_rgb[1],  16'hFFFF);
    check("xsplit_l32_x32", got_rgb[33], 16'h0000);

    // Gradient, pattern only.
    cfg_pattern = 2'd1;
    cfg_split   = 2'd0;
    cfg_pos     = 11'd0;
    vs_pulse();
    line(H, "grad_l0");
    check("grad_x0",    got_rgb[1],    16'h001F);
    check("grad_x32",   got_rgb[33],   16'h081E);
    check("grad_x1023", got_rgb[1024], 16'hF800);
    check("grad_x1279", got_rgb[1280], 16'h3818);
    lines(15, 4, "grad_mid");
    line(8, "grad_l16");
    check("grad_l16_x0", got_rgb[1], 16'h003F);

    // pos = 0: camera everywhere (line 0 is the boundary when bordered).
    cfg_pattern = 2'd3;
    cfg_split   = 2'd2;
    cfg_pos     = 11'd0;
    cam_rgb     = 16'h0F0F;
    vs_pulse();
    line(64, "pos0_l0");
    line(64, "pos0_l1");
    check("pos0_l1_x0", got_rgb[1], 16'h0F0F);

    // pos = 2047: pattern everywhere.
    cfg_split = 2'd3;
    cfg_pos   = 11'd2047;
    vs_pulse();
    line(H, "pos2047");
    check("pos2047_x1279", got_rgb[1280], 16'hFFFF);

    // Over-long de: x saturates at 1279, so x>=1280 never selects camera.
    cfg_pattern = 2'd0;
    cfg_split   = 2'd3;
    cfg_pos     = 11'd1280;
    vs_pulse();
    line(1400, "xsat");
    check("xsat_x1279", got_rgb[1280], 16'h0001);
    check("xsat_x1399", got_rgb[1400], 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
